// File: rtl/forward_bypass_pkg.sv
// Shared types and constants for the forward/bypass buffer.
// Optional statistics counters in the top are enabled with FWD_BYPASS_STATS_EN.
package forward_bypass_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int DEPTH_DEF          = 3;
  localparam int NUM_SRC_DEF        = 2;

  // Architectural x0: never forwards.
  localparam logic [REG_ADDR_WIDTH_DEF-1:0] REG_ZERO = {REG_ADDR_WIDTH_DEF{1'b0}};

  // One buffered result at the default widths.
  typedef struct packed {
    logic                          valid;
    logic                          pending;
    logic [REG_ADDR_WIDTH_DEF-1:0] rd;
    logic [DATA_WIDTH_DEF-1:0]     data;
  } fwd_entry_t;

  // Width of a stage index; a single-entry buffer still needs one bit.
  function automatic int stage_width(input int depth);
    if (depth <= 2) begin
      return 1;
    end else begin
      return $clog2(depth);
    end
  endfunction

endpackage

// File: rtl/forward_bypass_lookup.sv
// Single-channel forwarding lookup: combinational priority scan of the
// buffer, youngest (lowest index) matching valid entry wins. A match on a
// load-pending entry reports a hit with zero data and raises pend_hit.
// FWD_BYPASS_STATS_EN does not affect this module.
module forward_bypass_lookup
  import forward_bypass_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int DEPTH          = DEPTH_DEF,
  parameter int STAGE_W        = stage_width(DEPTH_DEF)
)(
  input  logic [DEPTH-1:0]                     valid,
  input  logic [DEPTH-1:0]                     pending,
  input  logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] rd,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0]     data,
  input  logic [REG_ADDR_WIDTH-1:0]            src_addr,
  output logic                                 hit,
  output logic [DATA_WIDTH-1:0]                fwd_data,
  output logic [STAGE_W-1:0]                   stage,
  output logic                                 pend_hit
);

  logic             src_live_s;
  logic [DEPTH-1:0] match_s;

  assign src_live_s = (src_addr != REG_ADDR_WIDTH'(REG_ZERO));

  // Per-entry address match, qualified by entry valid and a non-x0 source.
  always_comb begin
    match_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match_s[k] = valid[k] & (rd[k] == src_addr) & src_live_s;
    end
  end

  // Priority select: scan oldest to youngest so the youngest match is last to write.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    stage    = '0;
    pend_hit = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match_s[k]) begin
        hit      = 1'b1;
        stage    = STAGE_W'(k);
        pend_hit = pending[k];
        fwd_data = pending[k] ? {DATA_WIDTH{1'b0}} : data[k];
      end else begin
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/forward_bypass_buffer.sv
// Forward/bypass buffer: DEPTH-deep shift buffer of retired results with
// NUM_SRC operand lookup channels and load-use hazard detection.
// Entry 0 is the youngest (EX/MEM). Returning load data completes the oldest
// load-pending entry after this cycle's shift.
// Define FWD_BYPASS_STATS_EN to add per-stage hit counters and an orphan
// load-fill counter (all 32-bit, saturating).
module forward_bypass_buffer
  import forward_bypass_pkg::*;
#(
  parameter  int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter  int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter  int DEPTH          = DEPTH_DEF,
  parameter  int NUM_SRC        = NUM_SRC_DEF,
  localparam int STAGE_W        = stage_width(DEPTH)
)(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              stall_i,
  input  logic                              flush_i,
  input  logic                              res_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]         res_rd_i,
  input  logic [DATA_WIDTH-1:0]             res_data_i,
  input  logic                              res_load_i,
  input  logic                              ld_valid_i,
  input  logic [DATA_WIDTH-1:0]             ld_data_i,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] src_addr_i,
  output logic [NUM_SRC-1:0]                fwd_hit_o,
  output logic [NUM_SRC*DATA_WIDTH-1:0]     fwd_data_o,
  output logic [NUM_SRC*STAGE_W-1:0]        fwd_stage_o,
  output logic                              hazard_o
`ifdef FWD_BYPASS_STATS_EN
  ,
  output logic [DEPTH*32-1:0]               hit_cnt_o,
  output logic [31:0]                       orphan_fill_cnt_o
`endif
);

  // Buffer state, split per field so widths follow the module parameters.
  logic [DEPTH-1:0]                     valid_r;
  logic [DEPTH-1:0]                     pending_r;
  logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] rd_r;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]     data_r;

  logic [DEPTH-1:0]                     valid_nxt_s;
  logic [DEPTH-1:0]                     pending_nxt_s;
  logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] rd_nxt_s;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]     data_nxt_s;

  logic             shift_s;
  logic             ins_live_s;
  logic             pend_seen_s;
  logic [DEPTH-1:0] oldest_pend_s;
  logic [DEPTH-1:0] fill_src_s;
  logic [NUM_SRC-1:0] pend_hit_s;

  // Flush always advances the pipe (inserting a bubble); otherwise stall holds.
  assign shift_s    = flush_i | ~stall_i;
  // Writes to x0 are stored as invalid so they can never forward.
  assign ins_live_s = res_valid_i & ~flush_i & (res_rd_i != REG_ADDR_WIDTH'(REG_ZERO));

  // One-hot marker of the oldest load-pending entry in the current buffer.
  always_comb begin
    pend_seen_s   = 1'b0;
    oldest_pend_s = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (pending_r[j] && !pend_seen_s) begin
        oldest_pend_s[j] = 1'b1;
        pend_seen_s      = 1'b1;
      end else begin
        oldest_pend_s[j] = 1'b0;
      end
    end
  end

  // The fill targets the entry by its pre-shift position; it follows that entry.
  assign fill_src_s = ld_valid_i ? oldest_pend_s : {DEPTH{1'b0}};

  // Next buffer contents: shift or hold, then land the load fill in the entry's new slot.
  always_comb begin
    valid_nxt_s   = valid_r;
    pending_nxt_s = pending_r;
    rd_nxt_s      = rd_r;
    data_nxt_s    = data_r;
    if (shift_s) begin
      valid_nxt_s[0]   = ins_live_s;
      pending_nxt_s[0] = ins_live_s & res_load_i;
      rd_nxt_s[0]      = flush_i ? {REG_ADDR_WIDTH{1'b0}} : res_rd_i;
      data_nxt_s[0]    = (flush_i | res_load_i) ? {DATA_WIDTH{1'b0}} : res_data_i;
      for (int k = 1; k < DEPTH; k++) begin
        valid_nxt_s[k]   = valid_r[k-1];
        pending_nxt_s[k] = pending_r[k-1] & ~fill_src_s[k-1];
        rd_nxt_s[k]      = rd_r[k-1];
        data_nxt_s[k]    = fill_src_s[k-1] ? ld_data_i : data_r[k-1];
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_nxt_s[k]   = valid_r[k];
        pending_nxt_s[k] = pending_r[k] & ~fill_src_s[k];
        rd_nxt_s[k]      = rd_r[k];
        data_nxt_s[k]    = fill_src_s[k] ? ld_data_i : data_r[k];
      end
    end
  end

  // Buffer state register; reset clears everything, including pending loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r   <= '0;
      pending_r <= '0;
      rd_r      <= '0;
      data_r    <= '0;
    end else begin
      valid_r   <= valid_nxt_s;
      pending_r <= pending_nxt_s;
      rd_r      <= rd_nxt_s;
      data_r    <= data_nxt_s;
    end
  end

  // One lookup channel per source operand, reading the registered buffer.
  for (genvar c = 0; c < NUM_SRC; c++) begin : g_src
    forward_bypass_lookup #(
      .DATA_WIDTH     (DATA_WIDTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
      .DEPTH          (DEPTH),
      .STAGE_W        (STAGE_W)
    ) u_lookup (
      .valid    (valid_r),
      .pending  (pending_r),
      .rd       (rd_r),
      .data     (data_r),
      .src_addr (src_addr_i[c*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
      .hit      (fwd_hit_o[c]),
      .fwd_data (fwd_data_o[c*DATA_WIDTH +: DATA_WIDTH]),
      .stage    (fwd_stage_o[c*STAGE_W +: STAGE_W]),
      .pend_hit (pend_hit_s[c])
    );
  end

  assign hazard_o = |pend_hit_s;

`ifdef FWD_BYPASS_STATS_EN
  logic [DEPTH-1:0][31:0] hit_cnt_r;
  logic [31:0]            orphan_cnt_r;
  logic [DEPTH-1:0][31:0] hit_inc_s;
  logic [DEPTH-1:0][32:0] hit_sum_s;
  logic                   orphan_s;

  assign orphan_s = ld_valid_i & ~pend_seen_s;

  // Count this cycle's channel hits per stage and form the widened sums.
  always_comb begin
    hit_inc_s = '0;
    hit_sum_s = '0;
    for (int c = 0; c < NUM_SRC; c++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (fwd_hit_o[c] && (fwd_stage_o[c*STAGE_W +: STAGE_W] == STAGE_W'(k))) begin
          hit_inc_s[k] = hit_inc_s[k] + 32'd1;
        end else begin
          hit_inc_s[k] = hit_inc_s[k];
        end
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      hit_sum_s[k] = {1'b0, hit_cnt_r[k]} + {1'b0, hit_inc_s[k]};
    end
  end

  // Saturating statistics counters; hits only accrue on non-stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_r    <= '0;
      orphan_cnt_r <= 32'd0;
    end else begin
      if (!stall_i) begin
        for (int k = 0; k < DEPTH; k++) begin
          hit_cnt_r[k] <= hit_sum_s[k][32] ? 32'hFFFF_FFFF : hit_sum_s[k][31:0];
        end
      end else begin
        hit_cnt_r <= hit_cnt_r;
      end
      if (orphan_s && (orphan_cnt_r != 32'hFFFF_FFFF)) begin
        orphan_cnt_r <= orphan_cnt_r + 32'd1;
      end else begin
        orphan_cnt_r <= orphan_cnt_r;
      end
    end
  end

  assign hit_cnt_o         = hit_cnt_r;
  assign orphan_fill_cnt_o = orphan_cnt_r;
`endif

endmodule

// File: doc/forward_bypass_buffer.md
Name: forward_bypass_buffer

Overview:
- Parametrised successor to the single EX/MEM forward signal.
- Holds a DEPTH-deep shift buffer of retired-but-not-yet-written-back results: rd, data, valid and load-pending.
- Resolves forwarding for NUM_SRC source operands, youngest match wins, and flags load-use hazards.
- Sits between the EX stage result bus and the ID/EX operand muxes of the RISC-V core.

Parameters:
- DATA_WIDTH, 32, width of result and forwarded data.
- REG_ADDR_WIDTH, 5, register index width; index 0 is hard-zero and never forwards.
- DEPTH, 3, number of buffered pipeline stages; entry 0 is youngest (EX/MEM).
- NUM_SRC, 2, number of operand lookup channels.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  pipeline stall; buffer holds.
- flush_i  in  1  insert bubble instead of the current result.
- res_valid_i  in  1  EX result present this cycle.
- res_rd_i  in  REG_ADDR_WIDTH  destination register of the result.
- res_data_i  in  DATA_WIDTH  result value; ignored when res_load_i=1.
- res_load_i  in  1  result is a load; data not yet available.
- ld_valid_i  in  1  load data return.
- ld_data_i  in  DATA_WIDTH  returned load data.
- src_addr_i  in  NUM_SRC*REG_ADDR_WIDTH  packed lookup addresses; channel 0 in the LSBs.
- fwd_hit_o  out  NUM_SRC  matching valid entry found.
- fwd_data_o  out  NUM_SRC*DATA_WIDTH  forwarded data per channel.
- fwd_stage_o  out  NUM_SRC*STAGE_W  index of the matching entry; STAGE_W=$clog2(DEPTH) (min 1).
- hazard_o  out  1  any channel hits a load-pending entry.

Behaviour:
- Reset (async, rst=1):
  - All entries: valid=0, pending=0, rd=0, data=0.
  - Outputs immediately 0 (fwd_hit_o, fwd_data_o, fwd_stage_o, hazard_o).
- Shift, on each rising edge, priority flush > stall > normal:
  - flush_i=1 (regardless of stall_i): entry[k]<=entry[k-1] for k>=1; entry[0]<=invalid.
  - stall_i=1, flush_i=0: all entries hold.
  - Normal: entry[k]<=entry[k-1]; entry[0]<={res_valid_i, res_rd_i, res_load_i?0:res_data_i, res_valid_i&res_load_i}.
  - The oldest entry falls off.
- Write with rd=0: entry is stored valid=0, i.e. dropped.
- Load fill, ld_valid_i=1:
  - Completes the oldest pending entry with ld_data_i and clears its pending bit.
  - Applied after the shift: if the shift moves that entry, the fill lands in its new slot; if the entry shifts out, the fill is dropped.
  - No pending entry: fill ignored.
  - Only one fill per cycle.
- Lookup, combinational, zero latency:
  - Per channel c, scan k=0..DEPTH-1; first entry with valid && rd==src_addr[c] && src_addr[c]!=0 hits.
  - Hit: fwd_hit_o[c]=1, fwd_stage_o[c]=k, fwd_data_o[c]=entry[k].data.
  - Miss: fwd_hit_o[c]=0; data and stage outputs are 0.
  - Hit on a pending entry: fwd_hit_o[c]=1, fwd_data_o[c]=0, and hazard_o=1.
  - Same-cycle ld_valid_i does not bypass into lookup; the filled data is visible next cycle.
- Entries inserted this cycle are visible to lookup from the next cycle.
- Duplicate rd in several entries: the youngest (lowest k) wins, even if it is pending and an older entry holds ready data.
- Reset asserted mid-operation clears all state immediately, including pending loads; a subsequent ld_valid_i is ignored.

Optional Feature:
- Macro FWD_BYPASS_STATS_EN.
- Defined, adds:
  - Output hit_cnt_o, DEPTH*32 bits: one 32-bit saturating counter per stage, +1 per channel hit per non-stalled cycle.
  - Output orphan_fill_cnt_o, 32 bits, saturating: counts ld_valid_i with no pending entry.
  - All counters reset to 0 on rst.
- Not defined: ports and counters absent; core behaviour identical.

Decomposition:
- Package forward_bypass_pkg holds:
  - typedef fwd_entry_t struct {valid, pending, rd, data}, parametrised via package localparams matching the defaults.
  - Function for the stage-width clog2.
  - Constant REG_ZERO.
- One sub-module, forward_bypass_lookup: combinational priority scan for a single channel, instantiated NUM_SRC times in a generate loop.
- The shift, fill and stats logic stays in the top module.

Test Plan:
- Back-to-back dependency: cycle0 res rd=5 data=0xA5A5_0001; cycle1 src0=5 -> hit=1, stage=0, data=0xA5A5_0001; next two cycles stage=1 then 2; after DEPTH shifts, hit=0.
- Youngest wins: insert rd=3 data=0x11, then rd=3 data=0x22; lookup src1=3 -> data=0x22, stage=0.
- Load-use: insert rd=7 with res_load_i=1; lookup src0=7 -> hazard_o=1, hit=1, data=0.
  - Next cycle ld_valid_i data=0xDEAD_BEEF, then one cycle later -> hazard_o=0, data=0xDEAD_BEEF.
- Stall/flush: insert rd=4 data=0x44, then stall 3 cycles -> stage stays 0.
  - flush+stall together -> rd=4 moves to stage 1, entry 0 invalid.
- x0 and reset: insert rd=0 data=0xFF; lookup src=0 -> hit=0.
  - Assert rst mid-stream with entries valid -> all outputs 0 in the same cycle; after release, lookups miss.
- With FWD_BYPASS_STATS_EN: 5 hits at stage 0 gives hit_cnt[0]=5; ld_valid_i with no pending load gives orphan_fill_cnt_o=1; preloading a counter to 0xFFFF_FFFF and hitting again leaves it saturated.
